// File: rtl/cosx_job_if.sv
// Handshake bundle between the cos(x) job sequencer, the operand/result
// stream fabric and the accelerator start/done port.
// master: sequencer side.  slave: fabric + accelerator side.
interface cosx_job_if #(
    parameter int XW = 16,
    parameter int RW = 16
);
    logic          in_valid;
    logic [XW-1:0] in_x;
    logic          in_ready;
    logic          out_valid;
    logic [RW-1:0] out_r;
    logic          out_ready;
    logic          acc_start;
    logic [XW-1:0] acc_x;
    logic          acc_done;
    logic [RW-1:0] acc_r;

    modport master (
        input  in_valid, in_x, out_ready, acc_done, acc_r,
        output in_ready, out_valid, out_r, acc_start, acc_x
    );

    modport slave (
        output in_valid, in_x, out_ready, acc_done, acc_r,
        input  in_ready, out_valid, out_r, acc_start, acc_x
    );
endinterface

// File: rtl/cosx_job_sequencer.sv
// Host-side initiator for the cos(x) accelerator. Takes one operand at a
// time from the input stream, pulses acc_start, waits for acc_done (with a
// timeout), and pushes the result into a small output FIFO.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no job in flight; accepts an operand when accel idle + slot free
//  START   | acc_start held high for START_CYC cycles
//  WAIT    | waiting for acc_done; first cycle ignored, timer guards hang
//  CAPTURE | accelerator idle, acc_r final; push result, count the job
module cosx_job_sequencer #(
    parameter int XW        = 16,
    parameter int RW        = 16,
    parameter int DEPTH     = 4,
    parameter int START_CYC = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cosx_job_if.master        bus,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [15:0]       job_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int TW  = $clog2(TIMEOUT);

    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYC - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  FIFO_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t         state;
    logic [SCW-1:0] start_cnt;
    logic [TW-1:0]  timer;
    logic           acc_start_q;
    logic [XW-1:0]  acc_x_q;

    logic [RW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           accept;
    logic           push;
    logic           pop;

    // Only one job in flight, so a free slot at accept time guarantees
    // CAPTURE never meets a full FIFO.
    assign bus.in_ready  = (state == S_IDLE) & bus.acc_done & (count < FIFO_FULL);
    assign accept        = bus.in_valid & bus.in_ready;
    assign push          = (state == S_CAPTURE);
    assign pop           = (count != '0) & bus.out_ready;

    assign bus.out_valid = (count != '0);
    assign bus.out_r     = mem[rd_ptr];
    assign bus.acc_start = acc_start_q;
    assign bus.acc_x     = acc_x_q;
    assign busy          = (state != S_IDLE);

    // Job FSM: start pulse, done wait with timeout, result capture, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_cnt   <= '0;
            timer       <= '0;
            acc_start_q <= 1'b0;
            acc_x_q     <= '0;
            err_timeout <= 1'b0;
            job_cnt     <= '0;
        end else begin
            // A timeout in the same cycle overrides this clear below.
            if (err_clr)
                err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc_x_q     <= bus.in_x;
                        acc_start_q <= 1'b1;
                        start_cnt   <= '0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (start_cnt == START_LAST) begin
                        acc_start_q <= 1'b0;
                        timer       <= '0;
                        state       <= S_WAIT;
                    end else begin
                        start_cnt <= start_cnt + SCW'(1);
                    end
                end
                S_WAIT: begin
                    // timer==0 marks the first WAIT cycle, where acc_done may
                    // still reflect the pre-start idle level.
                    if ((timer != '0) && bus.acc_done) begin
                        state <= S_CAPTURE;
                    end else if (timer == TIMER_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_CAPTURE: begin
                    job_cnt <= job_cnt + 16'd1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO: head read straight from storage so a pushed entry is
    // visible the cycle after the push with no extra bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.acc_r;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cosx_job_sequencer.sv
// Directed bench for cosx_job_sequencer with a simple accelerator model:
// done drops when start is seen, rises 10 cycles after start falls with
// acc_r = ~acc_x. ext_busy masks done to mimic an externally busy/hung unit.
module tb_cosx_job_sequencer;
    localparam int XW        = 16;
    localparam int RW        = 16;
    localparam int DEPTH     = 4;
    localparam int START_CYC = 2;
    localparam int TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr;
    logic        busy;
    logic        err_timeout;
    logic [15:0] job_cnt;

    always #5 clk = ~clk;

    cosx_job_if #(.XW(XW), .RW(RW)) bus ();

    cosx_job_sequencer #(
        .XW(XW), .RW(RW), .DEPTH(DEPTH), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_clr(err_clr),
        .job_cnt(job_cnt)
    );

    logic          model_done;
    logic [RW-1:0] model_r;
    int            model_cnt;
    logic          ext_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b1;
            model_r    <= '0;
            model_cnt  <= 0;
        end else if (bus.acc_start) begin
            model_done <= 1'b0;
            model_cnt  <= 10;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) begin
                model_done <= 1'b1;
                model_r    <= ~bus.acc_x;
            end
        end
    end

    assign bus.acc_done = model_done & ~ext_busy;
    assign bus.acc_r    = model_r;

    typedef struct {
        logic [15:0] x;
        logic [15:0] exp_r;
    } vec_t;

    vec_t        vecs[6];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_jobs = 0;
    logic [15:0] got[$];
    int          viol;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push_op(input logic [15:0] x);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        #1;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
            #1;
        end
        if (n >= 500) expire("push_wait");
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name, output int n);
        n = 0;
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) expire(name);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_job(input logic [15:0] x, input logic [15:0] exp_r, input string tag);
        int n;
        push_op(x);
        chk({tag, "_acc_x"}, bus.acc_x, x);
        n = 0;
        while (bus.acc_start && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_start_len"}, n, START_CYC);
        wait_out_valid({tag, "_out_wait"}, n);
        // start falls -> 10 model cycles -> done sampled -> CAPTURE -> visible
        chk({tag, "_latency"}, n, 12);
        chk({tag, "_out_r"}, bus.out_r, exp_r);
        chk({tag, "_busy"}, busy, 0);
        exp_jobs++;
        chk({tag, "_job_cnt"}, job_cnt, exp_jobs);
        pop_one();
        chk({tag, "_empty"}, bus.out_valid, 0);
    endtask

    task automatic collect(input int n, input bit single);
        int  budget = 0;
        bit  prev = 0;
        got.delete();
        viol = 0;
        bus.out_ready = 1'b1;
        while (got.size() < n && budget < 2000) begin
            if (bus.out_valid) begin
                got.push_back(bus.out_r);
                if (single && prev) viol++;
            end
            prev = bus.out_valid;
            @(negedge clk);
            budget++;
        end
        bus.out_ready = 1'b0;
        if (got.size() < n) expire("collect");
    endtask

    initial begin
        int          n;
        int          bad;
        logic [15:0] e;

        vecs[0] = '{16'h1234, 16'hEDCB};
        vecs[1] = '{16'h0000, 16'hFFFF};
        vecs[2] = '{16'hFFFF, 16'h0000};
        vecs[3] = '{16'hA5A5, 16'h5A5A};
        vecs[4] = '{16'h0F0F, 16'hF0F0};
        vecs[5] = '{16'h8001, 16'h7FFE};

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        err_clr       = 1'b0;
        ext_busy      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_acc_start", bus.acc_start, 0);
        chk("rst_acc_x", bus.acc_x, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_r", bus.out_r, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_job_cnt", job_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // single jobs from the table
        for (int i = 0; i < 6; i++)
            run_job(vecs[i].x, vecs[i].exp_r, $sformatf("vec%0d", i));

        // back-to-back with a stalled consumer
        for (int i = 0; i < 4; i++)
            push_op(16'(i));
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) expire("b2b_idle");
        chk("b2b_head", bus.out_r, 16'hFFFF);
        bus.in_valid = 1'b1;
        bus.in_x     = 16'd4;
        bad = 0;
        repeat (5) begin
            if (bus.in_ready || bus.acc_start) bad++;
            @(negedge clk);
        end
        chk("b2b_full_block", bad, 0);
        fork
            begin
                push_op(16'd4);
                push_op(16'd5);
            end
            collect(6, 1'b0);
        join
        chk("b2b_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            e = ~16'(i);
            chk($sformatf("b2b_res%0d", i), got[i], e);
        end
        exp_jobs += 6;
        repeat (20) @(negedge clk);
        chk("b2b_no_dup", bus.out_valid, 0);
        chk("b2b_job_cnt", job_cnt, exp_jobs);

        // streaming with a consumer that is always ready
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push_op(16'h1000 + 16'(i) * 16'h0111);
            end
            collect(8, 1'b1);
        join
        chk("stream_count", got.size(), 8);
        chk("stream_occupancy", viol, 0);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            e = ~(16'h1000 + 16'(i) * 16'h0111);
            chk($sformatf("stream_res%0d", i), got[i], e);
        end
        exp_jobs += 8;
        chk("stream_job_cnt", job_cnt, exp_jobs);

        // externally busy accelerator holds off the launch
        bus.in_valid = 1'b1;
        bus.in_x     = 16'h0BAD;
        ext_busy     = 1'b1;
        #1;
        bad = 0;
        repeat (5) begin
            if (bus.in_ready || bus.acc_start) bad++;
            @(negedge clk);
        end
        chk("extbusy_block", bad, 0);
        ext_busy = 1'b0;
        #1;
        chk("extbusy_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("extbusy_launch", bus.acc_start, 1);
        wait_out_valid("extbusy_out", n);
        chk("extbusy_out_r", bus.out_r, 16'hF452);
        exp_jobs++;
        chk("extbusy_job_cnt", job_cnt, exp_jobs);
        pop_one();

        // timeout: done never seen
        push_op(16'h4242);
        ext_busy = 1'b1;
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, START_CYC + TIMEOUT);
        chk("to_out_valid", bus.out_valid, 0);
        chk("to_job_cnt", job_cnt, exp_jobs);
        chk("to_busy", busy, 0);
        ext_busy = 1'b0;
        #1;
        chk("to_in_ready", bus.in_ready, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_clr", err_timeout, 0);

        // timeout wins over a same-cycle clear
        err_clr = 1'b1;
        push_op(16'h4343);
        ext_busy = 1'b1;
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to2_latency", n, START_CYC + TIMEOUT);
        err_clr = 1'b0;
        @(negedge clk);
        chk("to2_sticky", err_timeout, 1);
        ext_busy = 1'b0;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to2_clr", err_timeout, 0);

        // reset in the middle of a WAIT with a result still buffered
        push_op(16'h5555);
        wait_out_valid("rst_setup", n);
        push_op(16'h7777);
        repeat (START_CYC + 3) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_acc_start", bus.acc_start, 0);
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_job_cnt", job_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_jobs = 0;
        @(negedge clk);
        run_job(16'hC0DE, 16'h3F21, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
